// File: rtl/object_overlay.sv
// Multi-object marker overlay: draws up to NUM_OBJ box/outline/crosshair markers
// over a greyscale pixel stream, with per-frame shadowed positions and lost-track blinking.
module object_overlay #(
    parameter int NUM_OBJ      = 2,
    parameter int COLOR_WIDTH  = 10,
    parameter int DISP_WIDTH   = 11,
    parameter int THICK        = 2,
    parameter int BLINK_FRAMES = 8,
    parameter int LOST_FRAMES  = 60
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic                          frame_start,
    input  logic [NUM_OBJ-1:0]            obj_valid,
    input  logic [NUM_OBJ*DISP_WIDTH-1:0] x_obj,
    input  logic [NUM_OBJ*DISP_WIDTH-1:0] y_obj,
    input  logic [DISP_WIDTH-1:0]         half_size,
    input  logic                          in_valid,
    input  logic [COLOR_WIDTH-1:0]        curr,
    input  logic [DISP_WIDTH-1:0]         x_pos,
    input  logic [DISP_WIDTH-1:0]         y_pos,
    output logic                          out_valid,
    output logic [COLOR_WIDTH-1:0]        r_out,
    output logic [COLOR_WIDTH-1:0]        g_out,
    output logic [COLOR_WIDTH-1:0]        b_out
);

    // Stream handshake: in_valid qualifies the pixel on the same cycle, there is no
    // backpressure, and out_valid is in_valid delayed by exactly the 2-stage latency.

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BOX   = 2'd1,
        MODE_OUTLN = 2'd2,
        MODE_CROSS = 2'd3
    } mode_e;

    localparam int LW = $clog2(LOST_FRAMES + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    localparam logic [LW-1:0]         LOST_MAX   = LW'(LOST_FRAMES);
    localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [DISP_WIDTH:0]   THICK_W    = (DISP_WIDTH + 1)'(THICK);
    localparam logic [COLOR_WIDTH-1:0] C_MAX     = '1;
    localparam logic [COLOR_WIDTH-1:0] C_ZERO    = '0;

    // Shadow (per-frame) state
    mode_e                  mode_s_q, mode_s_d;
    logic [DISP_WIDTH-1:0]  hs_s_q, hs_s_d;
    logic [DISP_WIDTH-1:0]  x_s_q [NUM_OBJ];
    logic [DISP_WIDTH-1:0]  x_s_d [NUM_OBJ];
    logic [DISP_WIDTH-1:0]  y_s_q [NUM_OBJ];
    logic [DISP_WIDTH-1:0]  y_s_d [NUM_OBJ];
    logic [LW-1:0]          lost_q [NUM_OBJ];
    logic [LW-1:0]          lost_d [NUM_OBJ];
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_phase_q, blink_phase_d;

    // Pipeline state
    logic [NUM_OBJ-1:0]     hit_d, hit_q;
    logic [COLOR_WIDTH-1:0] curr_q;
    logic                   valid_q;
    logic [COLOR_WIDTH-1:0] r_d, g_d, b_d;
    logic [IW-1:0]          win;
    logic                   any_hit;

    always_comb begin
        mode_s_d      = mode_s_q;
        hs_s_d        = hs_s_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        for (int i = 0; i < NUM_OBJ; i++) begin
            x_s_d[i]  = x_s_q[i];
            y_s_d[i]  = y_s_q[i];
            lost_d[i] = lost_q[i];
        end
        if (frame_start) begin
            mode_s_d = mode_e'(mode);
            hs_s_d   = half_size;
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (obj_valid[i]) begin
                    x_s_d[i]  = x_obj[i*DISP_WIDTH +: DISP_WIDTH];
                    y_s_d[i]  = y_obj[i*DISP_WIDTH +: DISP_WIDTH];
                    lost_d[i] = '0;
                end else if (lost_q[i] != LOST_MAX) begin
                    lost_d[i] = lost_q[i] + LW'(1);
                end
            end
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Lost counters reset to saturation so nothing is drawn before the first valid frame.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mode_s_q      <= MODE_PASS;
            hs_s_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_s_q[i]  <= '0;
                y_s_q[i]  <= '0;
                lost_q[i] <= LOST_MAX;
            end
        end else begin
            mode_s_q      <= mode_s_d;
            hs_s_q        <= hs_s_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_s_q[i]  <= x_s_d[i];
                y_s_q[i]  <= y_s_d[i];
                lost_q[i] <= lost_d[i];
            end
        end
    end

    // Stage 1 hit test; compares run one bit wider so dx+THICK cannot overflow.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
        logic [DISP_WIDTH-1:0] dx, dy;
        logic [DISP_WIDTH:0]   dx_e, dy_e, hs_e;
        logic                  in_box, on_edge, on_cross, visible, raw_hit;

        assign dx   = (x_pos >= x_s_q[gi]) ? (x_pos - x_s_q[gi]) : (x_s_q[gi] - x_pos);
        assign dy   = (y_pos >= y_s_q[gi]) ? (y_pos - y_s_q[gi]) : (y_s_q[gi] - y_pos);
        assign dx_e = {1'b0, dx};
        assign dy_e = {1'b0, dy};
        assign hs_e = {1'b0, hs_s_q};

        assign in_box   = (dx <= hs_s_q) && (dy <= hs_s_q);
        assign on_edge  = ((dx_e + THICK_W) > hs_e) || ((dy_e + THICK_W) > hs_e);
        assign on_cross = ((dx_e < THICK_W) && (dy <= hs_s_q)) ||
                          ((dy_e < THICK_W) && (dx <= hs_s_q));

        assign visible = (lost_q[gi] == '0) ||
                         ((lost_q[gi] != LOST_MAX) && blink_phase_q);

        assign raw_hit = (mode_s_q == MODE_BOX)   ? in_box :
                         (mode_s_q == MODE_OUTLN) ? (in_box && on_edge) :
                         (mode_s_q == MODE_CROSS) ? on_cross : 1'b0;

        assign hit_d[gi] = raw_hit && visible;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hit_q   <= '0;
            curr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            curr_q  <= curr;
            valid_q <= in_valid;
        end
    end

    // Stage 2: lowest-index hit wins; palette repeats every four objects.
    always_comb begin
        win     = '0;
        any_hit = 1'b0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win     = IW'(i);
                any_hit = 1'b1;
            end
        end
        r_d = curr_q;
        g_d = curr_q;
        b_d = curr_q;
        if (enable && any_hit) begin
            case (2'(win))
                2'd0:    begin r_d = C_MAX;  g_d = C_ZERO; b_d = C_ZERO; end
                2'd1:    begin r_d = C_ZERO; g_d = C_MAX;  b_d = C_ZERO; end
                2'd2:    begin r_d = C_ZERO; g_d = C_ZERO; b_d = C_MAX;  end
                default: begin r_d = C_MAX;  g_d = C_MAX;  b_d = C_ZERO; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
        end else begin
            out_valid <= valid_q;
            r_out     <= r_d;
            g_out     <= g_d;
            b_out     <= b_d;
        end
    end

endmodule

// File: tb/tb_object_overlay.sv
// Bench for object_overlay: directed scenarios plus randomized traffic, all checked
// against a frame-level behavioural model of the marker rules.
module tb_object_overlay;

    localparam int NOBJ   = 4;
    localparam int CW     = 10;
    localparam int DW     = 11;
    localparam int TH     = 2;
    localparam int BLINKF = 2;
    localparam int LOSTF  = 6;
    localparam logic [CW-1:0] CMAX = '1;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              enable;
    logic [1:0]        mode;
    logic              frame_start;
    logic [NOBJ-1:0]   obj_valid;
    logic [DW-1:0]     tx [NOBJ];
    logic [DW-1:0]     ty [NOBJ];
    logic [NOBJ*DW-1:0] x_obj, y_obj;
    logic [DW-1:0]     half_size;
    logic              in_valid;
    logic [CW-1:0]     curr;
    logic [DW-1:0]     x_pos, y_pos;
    logic              out_valid;
    logic [CW-1:0]     r_out, g_out, b_out;

    for (genvar gi = 0; gi < NOBJ; gi++) begin : g_pack
        assign x_obj[gi*DW +: DW] = tx[gi];
        assign y_obj[gi*DW +: DW] = ty[gi];
    end

    object_overlay #(
        .NUM_OBJ(NOBJ), .COLOR_WIDTH(CW), .DISP_WIDTH(DW),
        .THICK(TH), .BLINK_FRAMES(BLINKF), .LOST_FRAMES(LOSTF)
    ) dut (
        .clk(clk), .aresetn(aresetn), .enable(enable), .mode(mode),
        .frame_start(frame_start), .obj_valid(obj_valid),
        .x_obj(x_obj), .y_obj(y_obj), .half_size(half_size),
        .in_valid(in_valid), .curr(curr), .x_pos(x_pos), .y_pos(y_pos),
        .out_valid(out_valid), .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model state: what each object looks like at the frame level
    int m_x [NOBJ];
    int m_y [NOBJ];
    int m_lost [NOBJ];
    int m_bc;
    bit m_ph;
    int m_mode;
    int m_hs;

    typedef struct {
        logic          ov;
        logic [CW-1:0] c;
        logic          hit;
        logic [3*CW-1:0] hc;
        logic          en;
    } pend_t;

    pend_t pend[$];
    logic [3*CW:0] exp_q[$];
    logic [3*CW:0] act_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NOBJ; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_lost[i] = LOSTF;
        end
        m_bc = 0; m_ph = 0; m_mode = 0; m_hs = 0;
    endfunction

    function automatic void model_frame();
        m_mode = int'(mode);
        m_hs   = int'(half_size);
        for (int i = 0; i < NOBJ; i++) begin
            if (obj_valid[i]) begin
                m_x[i] = int'(tx[i]); m_y[i] = int'(ty[i]); m_lost[i] = 0;
            end else if (m_lost[i] < LOSTF) begin
                m_lost[i]++;
            end
        end
        m_bc++;
        if (m_bc == BLINKF) begin
            m_bc = 0; m_ph = !m_ph;
        end
    endfunction

    function automatic pend_t model_pix();
        pend_t p;
        int win = -1;
        for (int i = NOBJ - 1; i >= 0; i--) begin
            int dx, dy;
            bit box, hit, vis;
            dx  = (int'(x_pos) > m_x[i]) ? int'(x_pos) - m_x[i] : m_x[i] - int'(x_pos);
            dy  = (int'(y_pos) > m_y[i]) ? int'(y_pos) - m_y[i] : m_y[i] - int'(y_pos);
            box = (dx <= m_hs) && (dy <= m_hs);
            case (m_mode)
                1: hit = box;
                2: hit = box && ((dx + TH > m_hs) || (dy + TH > m_hs));
                3: hit = ((dx < TH) && (dy <= m_hs)) || ((dy < TH) && (dx <= m_hs));
                default: hit = 0;
            endcase
            vis = (m_lost[i] == 0) || ((m_lost[i] < LOSTF) && m_ph);
            if (hit && vis) win = i;
        end
        p.ov  = in_valid;
        p.c   = curr;
        p.hit = (win >= 0);
        p.en  = 1'b0;
        case (win % 4)
            0: p.hc = {CMAX, {CW{1'b0}}, {CW{1'b0}}};
            1: p.hc = {{CW{1'b0}}, CMAX, {CW{1'b0}}};
            2: p.hc = {{CW{1'b0}}, {CW{1'b0}}, CMAX};
            default: p.hc = {CMAX, CMAX, {CW{1'b0}}};
        endcase
        return p;
    endfunction

    // Drive current inputs for one clock; queue the model's prediction and, two
    // clocks on, the DUT output it must match.
    task automatic tick();
        pend_t p;
        if (pend.size() > 0) begin
            p = pend.pop_back();
            p.en = enable;
            pend.push_back(p);
        end
        p = model_pix();
        pend.push_back(p);
        if (frame_start) model_frame();
        @(posedge clk);
        #1;
        if (pend.size() == 2) begin
            p = pend.pop_front();
            exp_q.push_back({p.ov, (p.en && p.hit) ? p.hc : {p.c, p.c, p.c}});
            act_q.push_back({out_valid, r_out, g_out, b_out});
        end
    endtask

    task automatic frame(input logic [NOBJ-1:0] ov, input logic [1:0] md);
        obj_valid   = ov;
        mode        = md;
        frame_start = 1'b1;
        in_valid    = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    // One valid pixel followed by one idle cycle: afterwards the outputs show that pixel.
    task automatic px(input int x, input int y, input logic [CW-1:0] c);
        x_pos = DW'(x); y_pos = DW'(y); curr = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [3*CW:0] e, a;
        aresetn = 1'b0;
        in_valid = 1'b1; curr = 10'h2A5; x_pos = 5; y_pos = 5;
        model_reset();
        pend.delete();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_total++;
        if ({r_out, g_out, b_out} !== '0)
            $display("FAIL reset_rgb: got %h expected 0", {r_out, g_out, b_out});
        else n_pass++;
        aresetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            x_pos = DW'($urandom_range(0, 2047)); y_pos = DW'($urandom_range(0, 2047));
            curr = CW'($urandom); in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        px(0, 0, 10'h123);
        n_total++;
        if ({out_valid, r_out, g_out, b_out} !== {1'b1, 10'h123, 10'h123, 10'h123})
            $display("FAIL reset_passthru: got %h expected %h", {out_valid, r_out, g_out, b_out},
                     {1'b1, 10'h123, 10'h123, 10'h123});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL reset_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_box();
        logic [3*CW:0] e, a;
        tx[0] = 100; ty[0] = 100; half_size = 4; enable = 1'b1;
        frame(4'b0001, 2'd1);
        px(104, 100, 10'h155);
        n_total++;
        if ({out_valid, r_out, g_out, b_out} !== {1'b1, 10'h3FF, 10'h000, 10'h000})
            $display("FAIL box_edge_in: got %h expected %h", {out_valid, r_out, g_out, b_out},
                     {1'b1, 10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(105, 100, 10'h155);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h155, 10'h155, 10'h155})
            $display("FAIL box_edge_out: got %h expected %h", {r_out, g_out, b_out},
                     {10'h155, 10'h155, 10'h155});
        else n_pass++;
        px(100, 96, 10'h0F0);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL box_top_in: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            x_pos = DW'($urandom_range(92, 108)); y_pos = DW'($urandom_range(92, 108));
            curr = CW'($urandom); in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL box_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_outline_cross();
        logic [3*CW:0] e, a;
        half_size = 4;
        frame(4'b0001, 2'd2);
        px(100, 100, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0AA, 10'h0AA, 10'h0AA})
            $display("FAIL outline_centre: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0AA, 10'h0AA, 10'h0AA});
        else n_pass++;
        px(103, 100, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL outline_ring: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(102, 100, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0AA, 10'h0AA, 10'h0AA})
            $display("FAIL outline_inner: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0AA, 10'h0AA, 10'h0AA});
        else n_pass++;
        frame(4'b0001, 2'd3);
        px(100, 104, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL cross_arm: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(102, 102, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0AA, 10'h0AA, 10'h0AA})
            $display("FAIL cross_diag: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0AA, 10'h0AA, 10'h0AA});
        else n_pass++;
        half_size = 1;
        frame(4'b0001, 2'd2);
        px(100, 100, 10'h0AA);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL outline_thin_fill: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        for (int m = 2; m <= 3; m++) begin
            half_size = DW'($urandom_range(0, 7));
            frame(4'b0001, 2'(m));
            for (int k = 0; k < 40; k++) begin
                x_pos = DW'($urandom_range(91, 109)); y_pos = DW'($urandom_range(91, 109));
                curr = CW'($urandom); in_valid = 1'b1;
                tick();
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL outline_cross_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_priority_latch();
        logic [3*CW:0] e, a;
        tx[0] = 50; ty[0] = 50; tx[1] = 52; ty[1] = 50; half_size = 4;
        frame(4'b0011, 2'd1);
        px(51, 50, 10'h011);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL prio_overlap: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        tx[0] = 200;
        px(200, 50, 10'h022);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h022, 10'h022, 10'h022})
            $display("FAIL latch_hold: got %h expected %h", {r_out, g_out, b_out},
                     {10'h022, 10'h022, 10'h022});
        else n_pass++;
        // A pixel coinciding with frame_start still sees the old shadow position
        obj_valid = 4'b0011; frame_start = 1'b1;
        x_pos = 200; y_pos = 50; curr = 10'h033; in_valid = 1'b1;
        tick();
        frame_start = 1'b0; in_valid = 1'b0;
        tick();
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h033, 10'h033, 10'h033})
            $display("FAIL latch_same_cycle: got %h expected %h", {r_out, g_out, b_out},
                     {10'h033, 10'h033, 10'h033});
        else n_pass++;
        px(200, 50, 10'h044);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL latch_new_pos: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(51, 50, 10'h055);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h3FF, 10'h000})
            $display("FAIL prio_obj1: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h3FF, 10'h000});
        else n_pass++;
        tx[2] = 700; ty[2] = 700; tx[3] = 900; ty[3] = 900;
        frame(4'b1111, 2'd1);
        px(702, 699, 10'h066);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h000, 10'h3FF})
            $display("FAIL palette_blue: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h000, 10'h3FF});
        else n_pass++;
        px(896, 904, 10'h066);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h3FF, 10'h000})
            $display("FAIL palette_yellow: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h3FF, 10'h000});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL priority_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_edges();
        logic [3*CW:0] e, a;
        tx[0] = 0; ty[0] = 0; tx[1] = 2047; ty[1] = 2047; half_size = 3;
        frame(4'b0011, 2'd1);
        px(2047, 0, 10'h101);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h101, 10'h101, 10'h101})
            $display("FAIL edge_no_wrap: got %h expected %h", {r_out, g_out, b_out},
                     {10'h101, 10'h101, 10'h101});
        else n_pass++;
        px(2, 0, 10'h101);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL edge_origin: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(2047, 2044, 10'h101);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h3FF, 10'h000})
            $display("FAIL edge_max: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h3FF, 10'h000});
        else n_pass++;
        half_size = 0;
        frame(4'b0011, 2'd1);
        px(0, 0, 10'h202);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL hs0_centre: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        px(2046, 2047, 10'h202);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h202, 10'h202, 10'h202})
            $display("FAIL hs0_neighbour: got %h expected %h", {r_out, g_out, b_out},
                     {10'h202, 10'h202, 10'h202});
        else n_pass++;
        for (int k = 0; k < 30; k++) begin
            x_pos = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(2044, 2047));
            y_pos = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(2044, 2047));
            curr = CW'($urandom); in_valid = 1'b1;
            tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL edges_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_lost_blink();
        logic [3*CW:0] e, a;
        int vis_cnt;
        bit vis;
        tx[1] = 500; ty[1] = 300; half_size = 4;
        frame(4'b0010, 2'd1);
        px(500, 300, 10'h055);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h3FF, 10'h000})
            $display("FAIL lost_tracked: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h3FF, 10'h000});
        else n_pass++;
        vis_cnt = 0;
        for (int f = 1; f <= 9; f++) begin
            frame(4'b0000, 2'd1);
            px(500, 300, 10'h055);
            vis = (r_out == 10'h000) && (g_out == 10'h3FF) && (b_out == 10'h000);
            if (f <= 5) begin
                if (vis) vis_cnt++;
            end else begin
                n_total++;
                if ({r_out, g_out, b_out} !== {10'h055, 10'h055, 10'h055})
                    $display("FAIL lost_removed frame %0d: got %h expected %h", f,
                             {r_out, g_out, b_out}, {10'h055, 10'h055, 10'h055});
                else n_pass++;
            end
        end
        n_total++;
        if (vis_cnt < 2 || vis_cnt > 3)
            $display("FAIL blink_visible_frames: got %0d expected 2..3", vis_cnt);
        else n_pass++;
        frame(4'b0010, 2'd1);
        px(500, 300, 10'h055);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h3FF, 10'h000})
            $display("FAIL lost_reacquired: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h3FF, 10'h000});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL lost_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_enable_mode();
        logic [3*CW:0] e, a;
        logic [19:0] pat;
        tx[0] = 100; ty[0] = 100; half_size = 4; enable = 1'b0;
        frame(4'b0001, 2'd1);
        px(100, 100, 10'h0C3);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0C3, 10'h0C3, 10'h0C3})
            $display("FAIL enable_off: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0C3, 10'h0C3, 10'h0C3});
        else n_pass++;
        // enable matters in the cycle after the pixel, not the pixel's own cycle
        x_pos = 100; y_pos = 100; curr = 10'h0C3; in_valid = 1'b1; enable = 1'b1;
        tick();
        in_valid = 1'b0; enable = 1'b0;
        tick();
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0C3, 10'h0C3, 10'h0C3})
            $display("FAIL enable_stage2_off: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0C3, 10'h0C3, 10'h0C3});
        else n_pass++;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; enable = 1'b1;
        tick();
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h3FF, 10'h000, 10'h000})
            $display("FAIL enable_stage2_on: got %h expected %h", {r_out, g_out, b_out},
                     {10'h3FF, 10'h000, 10'h000});
        else n_pass++;
        frame(4'b0001, 2'd0);
        px(100, 100, 10'h0C3);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h0C3, 10'h0C3, 10'h0C3})
            $display("FAIL mode_pass: got %h expected %h", {r_out, g_out, b_out},
                     {10'h0C3, 10'h0C3, 10'h0C3});
        else n_pass++;
        frame(4'b0001, 2'd1);
        pat = 20'b1011_0011_1000_1101_0110;
        for (int k = 0; k < 20; k++) begin
            in_valid = pat[k];
            x_pos = DW'($urandom_range(95, 105)); y_pos = DW'($urandom_range(95, 105));
            curr = CW'($urandom);
            tick();
            if (k >= 1) begin
                n_total++;
                if (out_valid !== pat[k-1])
                    $display("FAIL valid_gap step %0d: got %b expected %b", k, out_valid, pat[k-1]);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL enable_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [3*CW:0] e, a;
        tx[1] = 500; ty[1] = 300; half_size = 4;
        frame(4'b0010, 2'd1);
        px(500, 300, 10'h077);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL midreset_pre_model: got %h expected %h", a, e); else n_pass++;
        end
        aresetn = 1'b0;
        model_reset();
        pend.delete();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        px(500, 300, 10'h077);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h077, 10'h077, 10'h077})
            $display("FAIL midreset_hidden: got %h expected %h", {r_out, g_out, b_out},
                     {10'h077, 10'h077, 10'h077});
        else n_pass++;
        frame(4'b0000, 2'd1);
        px(500, 300, 10'h077);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h077, 10'h077, 10'h077})
            $display("FAIL midreset_still_hidden: got %h expected %h", {r_out, g_out, b_out},
                     {10'h077, 10'h077, 10'h077});
        else n_pass++;
        frame(4'b0010, 2'd1);
        px(500, 300, 10'h077);
        n_total++;
        if ({r_out, g_out, b_out} !== {10'h000, 10'h3FF, 10'h000})
            $display("FAIL midreset_redrawn: got %h expected %h", {r_out, g_out, b_out},
                     {10'h000, 10'h3FF, 10'h000});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL midreset_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3*CW:0] e, a;
        for (int i = 0; i < NOBJ; i++) begin
            tx[i] = DW'($urandom_range(30, 200));
            ty[i] = DW'($urandom_range(30, 200));
        end
        for (int k = 0; k < 4000; k++) begin
            int j;
            if ($urandom_range(0, 199) == 0) begin
                j = $urandom_range(0, NOBJ - 1);
                tx[j] = DW'($urandom_range(30, 200));
                ty[j] = DW'($urandom_range(30, 200));
            end
            frame_start = ($urandom_range(0, 39) == 0);
            if (frame_start) begin
                obj_valid = NOBJ'($urandom);
                mode      = 2'($urandom);
                half_size = DW'($urandom_range(0, 12));
            end
            enable   = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom_range(0, 1));
            j = $urandom_range(0, NOBJ - 1);
            x_pos = DW'(int'(tx[j]) + int'($urandom_range(0, 30)) - 15);
            y_pos = DW'(int'(ty[j]) + int'($urandom_range(0, 30)) - 15);
            curr  = CW'($urandom);
            tick();
        end
        frame_start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL random_model: got %h expected %h", a, e); else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        aresetn = 1'b0;
        enable = 1'b1;
        mode = 2'd0;
        frame_start = 1'b0;
        obj_valid = '0;
        for (int i = 0; i < NOBJ; i++) begin
            tx[i] = '0;
            ty[i] = '0;
        end
        half_size = '0;
        in_valid = 1'b0;
        curr = '0;
        x_pos = '0;
        y_pos = '0;
        test_reset();
        test_box();
        test_outline_cross();
        test_priority_latch();
        test_edges();
        test_lost_blink();
        test_enable_mode();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/object_overlay.md
Name: object_overlay

Overview:
Multi-object marker overlay. It is the successor to the single-object red-square colouring stage and sits between the tracker's centre outputs and the VGA output, after the greyscale video path. It draws up to NUM_OBJ markers (filled box, outline or crosshair), each in its own colour. Object positions are double-buffered per frame so markers never tear mid-frame. An object that loses track blinks at its last known position and is then removed.

Parameters:
NUM_OBJ, 2, number of tracked objects (1..8)
COLOR_WIDTH, 10, bits per colour channel
DISP_WIDTH, 11, bits per screen coordinate
THICK, 2, outline/crosshair line thickness in pixels (>=1)
BLINK_FRAMES, 8, frames per blink half-period (>=1)
LOST_FRAMES, 60, frames a lost object is still drawn (>=1)

Ports:
clk  in  1  pixel clock
aresetn  in  1  reset; asynchronous, active-low
enable  in  1  overlay enable; low = pure greyscale pass-through
mode  in  2  0 pass, 1 filled box, 2 outline, 3 crosshair
frame_start  in  1  one-cycle pulse at start of frame; latches shadow regs
obj_valid  in  NUM_OBJ  per-object track-valid, sampled on frame_start
x_obj  in  NUM_OBJ*DISP_WIDTH  packed centres X, obj i at [i*DISP_WIDTH +: DISP_WIDTH]
y_obj  in  NUM_OBJ*DISP_WIDTH  packed centres Y, same packing
half_size  in  DISP_WIDTH  marker half-extent, shared by all objects
in_valid  in  1  pixel qualifier
curr  in  COLOR_WIDTH  greyscale pixel
x_pos, y_pos  in  DISP_WIDTH each  pixel coordinates
out_valid  out  1  in_valid delayed 2 cycles
r_out, g_out, b_out  out  COLOR_WIDTH each  output pixel

Behaviour:
- Reset (async, immediate): out_valid, r/g/b_out, pipeline regs, shadow x/y/mode/half_size = 0; lost_cnt[i] = LOST_FRAMES (nothing drawn); blink_cnt = 0; blink_phase = 0.
- Shadow latch: on a clk edge with frame_start=1, mode_s<=mode and hs_s<=half_size. Per object: if obj_valid[i], load x_s[i]/y_s[i] and set lost_cnt[i]<=0; else keep coords and saturating-increment lost_cnt[i] to LOST_FRAMES.
- Blink: each frame_start increments blink_cnt; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
- A pixel accepted in the same cycle as frame_start uses the pre-latch shadow values.
- Visibility per object: lost_cnt==0 → visible; 0<lost_cnt<LOST_FRAMES → visible only when blink_phase=1; lost_cnt==LOST_FRAMES → hidden.
- Stage 1 (registered): dx=|x_pos−x_s[i]|, dy=|y_pos−y_s[i]|, both unsigned DISP_WIDTH, no overflow. Compute hit[i] per mode_s:
  - box: dx<=hs && dy<=hs (inclusive).
  - outline: box && (dx+THICK>hs || dy+THICK>hs), with the addition done at DISP_WIDTH+1 bits. hs<THICK therefore degenerates to a filled box.
  - crosshair: (dx<THICK && dy<=hs) || (dy<THICK && dx<=hs).
  - mode 0: no hit.
  - hit[i] is gated by visibility. Register hit, curr and in_valid.
- Stage 2 (registered): if enable and any hit, the lowest hit index wins and outputs its palette colour by index mod 4: 0 red (max,0,0), 1 green (0,max,0), 2 blue (0,0,max), 3 yellow (max,max,0); max = all ones. Otherwise r=g=b=curr.
- enable is sampled at stage 2.
- Latency: fixed 2 cycles, data and out_valid aligned. Outputs update every cycle regardless of in_valid; consumers qualify with out_valid.
- hs_s=0: box is a single pixel at the centre.
- Coordinates at 0 or max: no wrap, abs-diff only.
- Reset mid-frame: all markers hidden until the next frame_start with obj_valid set.

Test Plan:
- Reset: hold aresetn=0 with in_valid=1 → out_valid=0, rgb=0. Release; pixels with no prior frame_start → r=g=b=curr (nothing drawn).
- Filled box: NUM_OBJ=2, obj0 valid (100,100), half_size=4, mode=1, frame_start. Pixel (104,100) curr=0x155 → 2 cycles later rgb=(0x3FF,0,0). Pixel (105,100) → rgb=0x155 each.
- Outline/crosshair: half_size=4, THICK=2, mode=2: (100,100) → curr; (103,100) → red. mode=3: (100,104) → red; (102,102) → curr.
- Priority/latch: obj0 (50,50), obj1 (52,50), size 4. Pixel (51,50) → red. Change x_obj mid-frame without frame_start → unchanged output. After frame_start → new position used.
- Lost/blink: BLINK_FRAMES=2, LOST_FRAMES=6. Drop obj_valid[1]. Marker visible only in frames where blink_phase=1; from the 6th invalid frame on → hidden permanently.
- enable=0 or mode=0 with a hit pixel → r=g=b=curr; out_valid tracks in_valid 2 cycles later for a gapped valid pattern.
